// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - data memory arbiter between the MEM-stage CPU port and the EXT loader/debug port
//
// Optional build macro: DMEM_ARB_RR_EN
//   undefined : CPU has priority; EXT is forced a slot after STARVE_MAX denied cycles
//   defined   : contended requests resolve round-robin
// LOCK (EXT burst ownership) behaves the same in both builds.

module dmem_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int DEPTH      = 256,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic              cpu_stall,

    input  logic              ext_req,
    input  logic              ext_we,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic [DATA_W-1:0] ext_wdata,
    input  logic              ext_lock,
    output logic              ext_gnt,
    output logic              ext_rvalid,

    output logic [DATA_W-1:0] rdata,

    output logic              mem_we,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CPU  = 2'd1,
        S_EXT  = 2'd2,
        S_LOCK = 2'd3
    } state_t;

    state_t state_q, state_d;

    // Read-return tracking: one read can be in flight, owner 0 = CPU, 1 = EXT
    logic rd_pend_q,  rd_pend_d;
    logic rd_owner_q, rd_owner_d;
    logic rd_oor_q,   rd_oor_d;
    logic err_q,      err_d;

    logic lock_hold;
    logic contended;
    logic ext_wins;
    logic any_gnt;
    logic win_we;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;
    logic out_of_range;

`ifdef DMEM_ARB_RR_EN
    // Round-robin pointer: port that wins the next contended cycle (0 = CPU)
    logic rr_ptr_q, rr_ptr_d;
`else
    localparam int SCW = $clog2(STARVE_MAX + 1);
    logic [SCW-1:0] starve_cnt_q, starve_cnt_d;
`endif

    // EXT keeps the port only while it both requests and holds the lock
    assign lock_hold = (state_q == S_LOCK) && ext_req && ext_lock;
    assign contended = cpu_req && ext_req && !lock_hold;

`ifdef DMEM_ARB_RR_EN
    assign ext_wins = rr_ptr_q;
`else
    assign ext_wins = (starve_cnt_q == SCW'(STARVE_MAX));
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: remember the last owner, enter LOCK on a locked EXT grant,
    // and release LOCK as soon as EXT stops holding it
    always_comb begin
        state_d = state_q;
        if (ext_gnt) begin
            state_d = ext_lock ? S_LOCK : S_EXT;
        end else if (cpu_gnt) begin
            state_d = S_CPU;
        end else if (state_q == S_LOCK) begin
            state_d = S_IDLE;
        end
    end

    // Grant outputs: combinational from requests and registered state, silent in reset
    always_comb begin
        cpu_gnt = 1'b0;
        ext_gnt = 1'b0;
        if (!rst) begin
            if (lock_hold) begin
                ext_gnt = 1'b1;
            end else if (contended) begin
                ext_gnt = ext_wins;
                cpu_gnt = !ext_wins;
            end else begin
                cpu_gnt = cpu_req;
                ext_gnt = ext_req;
            end
        end
    end

    assign cpu_stall = cpu_req && !cpu_gnt && !rst;
    assign any_gnt   = cpu_gnt || ext_gnt;

    // Winner select for the command bus; zeros when nobody is granted
    always_comb begin
        win_we    = 1'b0;
        win_addr  = '0;
        win_wdata = '0;
        if (ext_gnt) begin
            win_we    = ext_we;
            win_addr  = ext_addr;
            win_wdata = ext_wdata;
        end else if (cpu_gnt) begin
            win_we    = cpu_we;
            win_addr  = cpu_addr;
            win_wdata = cpu_wdata;
        end
    end

    assign out_of_range = any_gnt && (win_addr >= ADDR_W'(DEPTH));

    // Memory strobes are suppressed for out-of-range accesses, the grant still completes
    always_comb begin
        mem_we    = any_gnt && win_we && !out_of_range;
        mem_re    = any_gnt && !win_we && !out_of_range;
        mem_addr  = win_addr;
        mem_wdata = win_wdata;
    end

    // Fairness state update for the next cycle
`ifdef DMEM_ARB_RR_EN
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (contended && any_gnt) begin
            rr_ptr_d = !rr_ptr_q;
        end
    end

    // Round-robin pointer register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q <= 1'b0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`else
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (ext_gnt) begin
            starve_cnt_d = '0;
        end else if (ext_req && (starve_cnt_q != SCW'(STARVE_MAX))) begin
            starve_cnt_d = starve_cnt_q + SCW'(1);
        end
    end

    // Starvation counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end
`endif

    // Capture each granted read and any out-of-range access for the next cycle
    always_comb begin
        rd_pend_d  = any_gnt && !win_we;
        rd_owner_d = ext_gnt;
        rd_oor_d   = out_of_range;
        err_d      = out_of_range;
    end

    // Read-return and error registers; reset drops any read in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_pend_q  <= 1'b0;
            rd_owner_q <= 1'b0;
            rd_oor_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            rd_pend_q  <= rd_pend_d;
            rd_owner_q <= rd_owner_d;
            rd_oor_q   <= rd_oor_d;
            err_q      <= err_d;
        end
    end

    assign cpu_rvalid = rd_pend_q && !rd_owner_q;
    assign ext_rvalid = rd_pend_q && rd_owner_q;
    assign rdata      = (rd_pend_q && !rd_oor_q) ? mem_rdata : '0;
    assign err        = err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter

module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we, cpu_gnt, cpu_rvalid, cpu_stall;
    logic [31:0] cpu_addr, cpu_wdata;
    logic        ext_req, ext_we, ext_lock, ext_gnt, ext_rvalid;
    logic [31:0] ext_addr, ext_wdata;
    logic [31:0] rdata;
    logic        mem_we, mem_re;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata;
    logic        err;

    logic [31:0] mem [0:255];

    int n_assert = 0;
    int n_fail   = 0;
    logic ew, prev_ew;

    dmem_arbiter #(
        .DATA_W(32), .ADDR_W(32), .DEPTH(256), .STARVE_MAX(4)
    ) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_stall(cpu_stall),
        .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
        .ext_lock(ext_lock), .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid),
        .rdata(rdata),
        .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .err(err)
    );

    always #5 clk = ~clk;

    // Synchronous single-port memory behind the arbiter
    always @(posedge clk) begin
        if (mem_re) mem_rdata <= mem[mem_addr[7:0]];
        if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected contention winner on the i-th consecutive contended cycle (1 = EXT)
    function automatic logic ext_expected(input int i);
`ifdef DMEM_ARB_RR_EN
        return (i % 2) == 1;
`else
        return (i % 5) == 4;
`endif
    endfunction

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + i;
        mem_rdata = 32'h0;
        rst = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'd5; cpu_wdata = 32'h0;
        ext_req = 1'b1; ext_we = 1'b0; ext_addr = 32'd0; ext_wdata = 32'h0; ext_lock = 1'b0;

        // Reset: everything quiet even with requests present
        @(negedge clk); #1;
        chk("rst_outs", 32'(|{cpu_gnt, ext_gnt, cpu_stall, cpu_rvalid, ext_rvalid, mem_we, mem_re,
                              err, mem_addr, mem_wdata, rdata}), 32'h0);

        // Lone CPU read at address 5
        @(negedge clk);
        rst = 1'b0; ext_req = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'd5;
        #1;
        chk("rd5_gnt", 32'(cpu_gnt), 32'h1);
        chk("rd5_ext_gnt", 32'(ext_gnt), 32'h0);
        chk("rd5_re", 32'(mem_re), 32'h1);
        chk("rd5_we", 32'(mem_we), 32'h0);
        chk("rd5_addr", mem_addr, 32'd5);
        chk("rd5_stall", 32'(cpu_stall), 32'h0);
        @(negedge clk);
        cpu_req = 1'b0;
        #1;
        chk("rd5_rvalid", 32'(cpu_rvalid), 32'h1);
        chk("rd5_ext_rvalid", 32'(ext_rvalid), 32'h0);
        chk("rd5_rdata", rdata, 32'h1000_0005);
        chk("rd5_stall2", 32'(cpu_stall), 32'h0);
        chk("rd5_err", 32'(err), 32'h0);

        // Ten cycles of contention: CPU reads 6, EXT reads 7
        prev_ew = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'd6;
            ext_req = 1'b1; ext_we = 1'b0; ext_addr = 32'd7; ext_lock = 1'b0;
            #1;
            ew = ext_expected(i);
            chk($sformatf("cont%0d_cpu_gnt", i), 32'(cpu_gnt), 32'(!ew));
            chk($sformatf("cont%0d_ext_gnt", i), 32'(ext_gnt), 32'(ew));
            chk($sformatf("cont%0d_stall", i), 32'(cpu_stall), 32'(ew));
            if (i > 0) begin
                chk($sformatf("cont%0d_ext_rvalid", i), 32'(ext_rvalid), 32'(prev_ew));
                chk($sformatf("cont%0d_rdata", i), rdata, prev_ew ? 32'h1000_0007 : 32'h1000_0006);
            end
            prev_ew = ew;
        end
        @(negedge clk);
        cpu_req = 1'b0; ext_req = 1'b0;
        #1;
        chk("cont_last_ext_rvalid", 32'(ext_rvalid), 32'h1);
        chk("cont_last_rdata", rdata, 32'h1000_0007);

        // Locked EXT burst of four writes, CPU joins on the second beat
        @(negedge clk);
        ext_req = 1'b1; ext_we = 1'b1; ext_lock = 1'b1; ext_addr = 32'd10; ext_wdata = 32'hDEAD_0000;
        #1;
        chk("burst0_ext_gnt", 32'(ext_gnt), 32'h1);
        chk("burst0_we", 32'(mem_we), 32'h1);
        chk("burst0_addr", mem_addr, 32'd10);
        chk("burst0_wdata", mem_wdata, 32'hDEAD_0000);
        for (int b = 1; b < 4; b++) begin
            @(negedge clk);
            cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'd10;
            ext_addr = 32'd10 + b; ext_wdata = 32'hDEAD_0000 + b;
            #1;
            chk($sformatf("burst%0d_ext_gnt", b), 32'(ext_gnt), 32'h1);
            chk($sformatf("burst%0d_cpu_gnt", b), 32'(cpu_gnt), 32'h0);
            chk($sformatf("burst%0d_stall", b), 32'(cpu_stall), 32'h1);
            chk($sformatf("burst%0d_addr", b), mem_addr, 32'd10 + b);
            chk($sformatf("burst%0d_ext_rvalid", b), 32'(ext_rvalid), 32'h0);
        end
        @(negedge clk);
        ext_req = 1'b0; ext_lock = 1'b0;
        #1;
        chk("unlock_cpu_gnt", 32'(cpu_gnt), 32'h1);
        chk("unlock_stall", 32'(cpu_stall), 32'h0);
        chk("unlock_re", 32'(mem_re), 32'h1);
        chk("unlock_addr", mem_addr, 32'd10);

        // EXT overwrites address 10 right after the CPU read: old data returns
        @(negedge clk);
        cpu_req = 1'b0;
        ext_req = 1'b1; ext_we = 1'b1; ext_addr = 32'd10; ext_wdata = 32'h0000_5555;
        #1;
        chk("raw_ext_gnt", 32'(ext_gnt), 32'h1);
        chk("raw_we", 32'(mem_we), 32'h1);
        chk("raw_cpu_rvalid", 32'(cpu_rvalid), 32'h1);
        chk("raw_rdata_old", rdata, 32'hDEAD_0000);
        @(negedge clk);
        ext_req = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'd10;
        #1;
        chk("raw_rd_gnt", 32'(cpu_gnt), 32'h1);
        chk("raw_wr_no_rvalid", 32'(ext_rvalid), 32'h0);
        @(negedge clk);
        cpu_req = 1'b0;
        #1;
        chk("raw_rdata_new", rdata, 32'h0000_5555);

        // Out-of-range write and read at 300, then in-range boundary 255
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'd300; cpu_wdata = 32'h1234;
        #1;
        chk("oor_wr_gnt", 32'(cpu_gnt), 32'h1);
        chk("oor_wr_we", 32'(mem_we), 32'h0);
        chk("oor_wr_re", 32'(mem_re), 32'h0);
        @(negedge clk);
        cpu_we = 1'b0;
        #1;
        chk("oor_wr_err", 32'(err), 32'h1);
        chk("oor_wr_no_rvalid", 32'(cpu_rvalid), 32'h0);
        chk("oor_rd_gnt", 32'(cpu_gnt), 32'h1);
        chk("oor_rd_re", 32'(mem_re), 32'h0);
        @(negedge clk);
        cpu_req = 1'b0;
        #1;
        chk("oor_rd_err", 32'(err), 32'h1);
        chk("oor_rd_rvalid", 32'(cpu_rvalid), 32'h1);
        chk("oor_rd_rdata", rdata, 32'h0);
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'd255;
        #1;
        chk("edge_err_clear", 32'(err), 32'h0);
        chk("edge_re", 32'(mem_re), 32'h1);
        @(negedge clk);
        cpu_req = 1'b0;
        #1;
        chk("edge_err", 32'(err), 32'h0);
        chk("edge_rvalid", 32'(cpu_rvalid), 32'h1);
        chk("edge_rdata", rdata, 32'h1000_00FF);

        // Contention, EXT read, then reset with the read in flight
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'd2;
        ext_req = 1'b1; ext_we = 1'b0; ext_addr = 32'd3; ext_lock = 1'b0;
        #1;
        chk("pre_rst_cpu_gnt", 32'(cpu_gnt), 32'h1);
        @(negedge clk);
        cpu_req = 1'b0;
        #1;
        chk("pre_rst_ext_gnt", 32'(ext_gnt), 32'h1);
        chk("pre_rst_addr", mem_addr, 32'd3);
        @(negedge clk);
        rst = 1'b1; cpu_req = 1'b1;
        #1;
        chk("rst_ext_rvalid", 32'(ext_rvalid), 32'h0);
        chk("rst_outs_mid", 32'(|{cpu_gnt, ext_gnt, cpu_stall, cpu_rvalid, ext_rvalid, mem_we, mem_re,
                                  err, mem_addr, mem_wdata, rdata}), 32'h0);
        @(negedge clk);
        #1;
        chk("rst_outs_hold", 32'(|{cpu_gnt, ext_gnt, cpu_stall, cpu_rvalid, ext_rvalid, mem_we, mem_re,
                                   err, mem_addr, mem_wdata, rdata}), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_cpu_gnt", 32'(cpu_gnt), 32'h1);
        chk("post_rst_ext_gnt", 32'(ext_gnt), 32'h0);
        chk("post_rst_ext_rvalid", 32'(ext_rvalid), 32'h0);
        @(negedge clk);
        cpu_req = 1'b0; ext_req = 1'b0;
        #1;
        chk("post_rst_cpu_rvalid", 32'(cpu_rvalid), 32'h1);
        chk("post_rst_no_ext_rvalid", 32'(ext_rvalid), 32'h0);
        chk("post_rst_rdata", rdata, 32'h1000_0002);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
